// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte types, FIPS-197 S-box tables and a lookup helper.
package aes_pkg;

    typedef logic [0:127] state_t;
    typedef logic [7:0]   byte_t;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic byte_t sbox_lookup(byte_t b, bit inv);
        return inv ? INV_SBOX[b] : SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte combinational AES S-box (forward or inverse, fixed at elaboration).
module aes_sbox
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = sbox_lookup(din, INVERSE);

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative SubBytes: NUM_SBOX bytes of the latched state are substituted per cycle,
// result held in the state register until the consumer takes it.
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int NUM_SBOX = 4,
    parameter bit INVERSE  = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] message,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] crypte,
    output logic         busy
);

    localparam int NUM_STEPS = 16 / NUM_SBOX;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t                      fsm;
    logic [CNT_W-1:0]          cnt;
    state_t                    data;
    logic [NUM_SBOX-1:0][7:0]  sub_in;
    logic [NUM_SBOX-1:0][7:0]  sub_out;

    // Bit offset of the byte handled by a given lane in the current step.
    function automatic logic [6:0] byte_pos(logic [CNT_W-1:0] c, int lane);
        return 7'((int'(c) * NUM_SBOX + lane) * 8);
    endfunction

    // Byte mux: pick this step's window of bytes out of the state register.
    always_comb begin
        sub_in = '0;
        for (int i = 0; i < NUM_SBOX; i++) begin
            sub_in[i] = data[byte_pos(cnt, i) +: 8];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SBOX; g++) begin : g_sbox
            aes_sbox #(.INVERSE(INVERSE)) u_sbox (
                .din  (sub_in[g]),
                .dout (sub_out[g])
            );
        end
    endgenerate

    // Output is the state register itself; it only ever changes while out_valid is low.
    assign crypte = data;

    // Control FSM with registered handshake flags and in-place byte write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            cnt       <= '0;
            data      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        data     <= message;
                        cnt      <= '0;
                        fsm      <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < NUM_SBOX; i++) begin
                        data[byte_pos(cnt, i) +: 8] <= sub_out[i];
                    end
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // No new acceptance this cycle: in_ready rises only once back in IDLE.
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: six instances (NUM_SBOX 4/1/2/8/16 forward, 4 inverse) on shared inputs.
// Reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_seq;

    localparam int NI = 6;
    localparam int NSB [NI] = '{4, 1, 2, 8, 16, 4};
    localparam int LAT [NI] = '{4, 16, 8, 2, 1, 4};

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [0:127] message;
    logic         ir [NI];
    logic         ov [NI];
    logic         bz [NI];
    logic [0:127] cr [NI];

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   fwd [256];
    logic [7:0]   invt [256];
    int           lat [NI];
    logic [127:0] cap [NI];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            sub_bytes_seq #(.NUM_SBOX(NSB[g]), .INVERSE(g == 5)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (ir[g]),
                .message   (message),
                .out_valid (ov[g]),
                .out_ready (out_ready),
                .crypte    (cr[g]),
                .busy      (bz[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] b, int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Apply the byte table to each of the 16 bytes (byte 0 is the leftmost).
    function automatic logic [127:0] model(logic [127:0] s, bit inv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[127-8*k -: 8] = inv ? invt[s[127-8*k -: 8]] : fwd[s[127-8*k -: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present msg for one edge (instance 0 is idle), then scramble the input bus.
    task automatic send(input logic [127:0] msg);
        in_valid = 1'b1;
        message = msg;
        @(negedge clk);
        in_valid = 1'b0;
        message = rnd128();
    endtask

    // Record, per instance, the first cycle after acceptance at which out_valid is seen.
    task automatic measure();
        for (int i = 0; i < NI; i++) begin
            lat[i] = -1;
            cap[i] = '0;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (lat[i] < 0 && ov[i]) begin
                    lat[i] = c;
                    cap[i] = cr[i];
                end
            end
        end
    endtask

    initial begin
        logic [127:0] held;
        logic [127:0] m;
        logic [127:0] exp;
        logic [127:0] q [$];
        int n;
        int sent;
        int got;
        int cyc;

        // Reference tables: multiplicative inverse followed by the affine transform.
        for (int x = 0; x < 256; x++) begin
            logic [7:0] a;
            logic [7:0] r;
            a = 8'(x);
            r = 8'h01;
            for (int i = 0; i < 254; i++) r = gmul(r, a);
            fwd[x] = r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) invt[fwd[x]] = 8'(x);

        message = '0;
        do_reset();
        chk("rst_in_ready", 128'(ir[0]), 128'd1);
        chk("rst_out_valid", 128'(ov[0]), 128'd0);
        chk("rst_busy", 128'(bz[0]), 128'd0);
        chk("rst_crypte", cr[0], 128'd0);

        // Single byte values with default parameters.
        out_ready = 1'b1;
        send({16{8'h00}});
        measure();
        chk("zero_lat", 128'(lat[0]), 128'd4);
        chk("zero_data", cap[0], {16{8'h63}});
        do_reset();
        out_ready = 1'b1;
        send({16{8'h53}});
        measure();
        chk("x53_data", cap[0], {16{8'hed}});
        chk("x53_model", cap[0], model({16{8'h53}}, 1'b0));

        // FIPS vector across the parameter sweep.
        do_reset();
        out_ready = 1'b1;
        send(FIPS_IN);
        measure();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fips_data_%0d", NSB[i]), cap[i], FIPS_OUT);
            chk($sformatf("fips_lat_%0d", NSB[i]), 128'(lat[i]), 128'(LAT[i]));
        end
        chk("inv_fwd_in", cap[5], model(FIPS_IN, 1'b1));
        chk("inv_lat", 128'(lat[5]), 128'(LAT[5]));
        do_reset();
        out_ready = 1'b1;
        send(FIPS_OUT);
        measure();
        chk("inv_recover", cap[5], FIPS_IN);

        // Backpressure: output must hold while out_ready is low.
        do_reset();
        m = rnd128();
        send(m);
        n = 0;
        while (!ov[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 128'(ov[0]), 128'd1);
        held = cr[0];
        chk("bp_data", held, model(m, 1'b0));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", 128'(ov[0]), 128'd1);
            chk("bp_hold_data", cr[0], held);
            chk("bp_hold_ready", 128'(ir[0]), 128'd0);
            chk("bp_hold_busy", 128'(bz[0]), 128'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_rel_ready", 128'(ir[0]), 128'd1);
        chk("bp_rel_valid", 128'(ov[0]), 128'd0);
        chk("bp_rel_busy", 128'(bz[0]), 128'd0);

        // Reset two cycles after acceptance.
        out_ready = 1'b1;
        send(rnd128());
        @(negedge clk);
        chk("mid_no_valid", 128'(ov[0]), 128'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_ready", 128'(ir[0]), 128'd1);
        chk("mid_valid", 128'(ov[0]), 128'd0);
        chk("mid_crypte", cr[0], 128'd0);
        for (int c = 0; c < 6; c++) @(negedge clk);
        chk("mid_still_idle", 128'(ov[0]), 128'd0);
        m = rnd128();
        send(m);
        measure();
        chk("mid_next_lat", 128'(lat[0]), 128'd4);
        chk("mid_next_data", cap[0], model(m, 1'b0));

        // Random back-to-back traffic on the default instance, scoreboarded in order.
        do_reset();
        sent = 0;
        got = 0;
        cyc = 0;
        while ((sent < 1000 || got < 1000) && cyc < 40000) begin
            if (sent < 1000) begin
                in_valid = ($urandom_range(0, 3) != 0);
                message = rnd128();
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (ir[0] && in_valid) begin
                q.push_back(model(message, 1'b0));
                sent++;
            end
            if (ov[0] && out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : ~cr[0];
                chk("rnd_data", cr[0], exp);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("rnd_count", 128'(got), 128'd1000);
        chk("rnd_drain", 128'(q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
